// File: rtl/aes_pkg.sv
// ============================================================================
// Module : aes_pkg
// Shared types, round count and GF(2^8) helpers for the AES-128 round engine.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

   localparam int AES_NR = 10;

   typedef logic [127:0] aes_state_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } aes_ctrl_state_e;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (square-and-multiply), then the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] inv;
      logic [7:0] sq;
      inv = 8'h01;
      sq  = a;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

endpackage

`default_nettype wire

// File: rtl/aes_round_dp.sv
// ============================================================================
// Module : aes_round_dp
// Combinational AES round: SubBytes -> ShiftRows -> MixColumns (skipped on
// the final round) -> AddRoundKey.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module aes_round_dp
   import aes_pkg::*;
(
   input  aes_state_t state_in,
   input  aes_state_t rk,
   input  logic       final_round,
   output aes_state_t state_out
);

   logic [7:0] sb [16];
   logic [7:0] sr [16];
   logic [7:0] mc [16];

   // Byte i sits at row i%4, column i/4 (column-major, byte0 in the MSBs).
   for (genvar i = 0; i < 16; i++) begin : g_byte
      assign sb[i] = sbox(state_in[127-8*i -: 8]);
      assign sr[i] = sb[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
      assign state_out[127-8*i -: 8] = (final_round ? sr[i] : mc[i]) ^ rk[127-8*i -: 8];
   end

   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign mc[4*c+r] = xtime(sr[4*c+r]) ^ xtime(sr[4*c+(r+1)%4]) ^ sr[4*c+(r+1)%4]
                          ^ sr[4*c+(r+2)%4] ^ sr[4*c+(r+3)%4];
      end
   end

endmodule

`default_nettype wire

// File: rtl/aes_round_ctrl.sv
// ============================================================================
// Module : aes_round_ctrl
// Iterative AES-128 encryption sequencer, one round per clock on a shared
// datapath. Optional performance counters under `AES_PERF_CNT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int NR    = AES_NR,
   parameter int KEY_W = 128
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [KEY_W-1:0] in_data,
   output logic [3:0]       rk_idx,
   input  logic [KEY_W-1:0] rk_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [KEY_W-1:0] out_data,
   output logic             busy
`ifdef AES_PERF_CNT_EN
   ,
   output logic [31:0]      blk_count,
   output logic [31:0]      stall_count
`endif
);

   aes_ctrl_state_e state;
   logic [3:0]      round;
   aes_state_t      state_reg;
   aes_state_t      dp_next;

   aes_round_dp u_dp (
      .state_in    (state_reg),
      .rk          (rk_data),
      .final_round (state == FINAL),
      .state_out   (dp_next)
   );

   always_comb begin
      rk_idx = round;
      if (state == IDLE)       rk_idx = 4'd0;
      else if (state == FINAL) rk_idx = 4'(NR);
   end

   assign out_data = state_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         round     <= 4'd0;
         state_reg <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state_reg <= in_data ^ rk_data;
                  round     <= 4'd1;
                  state     <= ROUND;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            ROUND: begin
               state_reg <= dp_next;
               round     <= round + 4'd1;
               if (round == 4'(NR - 1)) state <= FINAL;
            end
            FINAL: begin
               state_reg <= dp_next;
               state     <= DONE;
               out_valid <= 1'b1;
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef AES_PERF_CNT_EN
   // Block count wraps; stall count saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_count   <= 32'd0;
         stall_count <= 32'd0;
      end else if (state == DONE) begin
         if (out_ready)                 blk_count   <= blk_count + 32'd1;
         else if (stall_count != '1)    stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
// ============================================================================
// Module : tb_aes_round_ctrl
// Directed self-checking bench for aes_round_ctrl against a table-driven model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_aes_round_ctrl;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;
`ifdef AES_PERF_CNT_EN
   logic [31:0]  blk_count;
   logic [31:0]  stall_count;
`endif

   int checks = 0;
   int errors = 0;

   logic [2047:0] sbox_tbl;
   logic [127:0]  rkeys [11];

   always #5 clk = ~clk;

   aes_round_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .rk_idx      (rk_idx),
      .rk_data     (rk_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .busy        (busy)
`ifdef AES_PERF_CNT_EN
      ,
      .blk_count   (blk_count),
      .stall_count (stall_count)
`endif
   );

   // External round-key store
   always_comb begin
      rk_data = '0;
      if (rk_idx <= 4'd10) rk_data = rkeys[rk_idx];
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] tsb(input logic [7:0] x);
      return sbox_tbl[2047 - 8*int'(x) -: 8];
   endfunction

   function automatic logic [7:0] m2(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   task automatic expand_key(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {t[23:0], t[31:24]};
            t  = {tsb(t[31:24]), tsb(t[23:16]), tsb(t[15:8]), tsb(t[7:0])} ^ {rc, 24'h0};
            rc = m2(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rkeys[0][127-8*i -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = tsb(s[i]);
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) s[4*c+w] = t[4*((c+w)%4)+w];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3;
               s[4*c+3] = m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rkeys[r][127-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_block(input logic [127:0] pt, input int stalls,
                             output logic [127:0] ct, output logic seen);
      in_data   = pt;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      for (int k = 0; k < 20 && !in_ready; k++) tick();
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 20 && !out_valid; k++) tick();
      seen = out_valid;
      ct   = out_data;
      for (int k = 0; k < stalls; k++) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   initial begin
      logic [127:0] pt [3];
      logic [127:0] ex [3];
      int           acc_cyc [3];
      int           n_acc, n_out;
      logic         acc_now, out_now, seen;
      logic [127:0] ct;

      sbox_tbl = {
         128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
         128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
         128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
         128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
         128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
         128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
         128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
         128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
      expand_key(C1_KEY);

      // Reset values
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      tick(); tick();
      chk("rst_in_ready", 128'(in_ready), 128'd1);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_out_data", out_data, 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_rk_idx", 128'(rk_idx), 128'd0);
      rst_n = 1'b1;
      tick();

      // FIPS-197 C.1 with latency and rk_idx trace
      in_data = C1_PT; in_valid = 1'b1;
      chk("c1_in_ready_T", 128'(in_ready), 128'd1);
      chk("c1_rk_idx_0", 128'(rk_idx), 128'd0);
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         chk($sformatf("c1_rk_idx_%0d", k), 128'(rk_idx), 128'(k));
         chk("c1_in_ready_busy", {126'd0, in_ready, busy}, 128'b01);
         chk("c1_early_valid", 128'(out_valid), 128'd0);
         tick();
      end
      chk("c1_valid_T11", 128'(out_valid), 128'd1);
      chk("c1_ct_fips", out_data, C1_CT);
      chk("c1_ct_model", out_data, model_encrypt(C1_PT));

      // Backpressure with a competing input offer
      in_valid = 1'b1; in_data = ~C1_PT;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("bp_data_stable", out_data, C1_CT);
         chk("bp_valid_ready", {126'd0, out_valid, in_ready}, 128'b10);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("bp_release_valid", 128'(out_valid), 128'd0);
      chk("bp_release_in_ready", 128'(in_ready), 128'd1);
      chk("bp_release_busy", 128'(busy), 128'd0);

      // Back-to-back blocks with in_valid held high
      for (int b = 0; b < 3; b++) begin
         pt[b] = {$urandom, $urandom, $urandom, $urandom};
         ex[b] = model_encrypt(pt[b]);
      end
      n_acc = 0; n_out = 0;
      in_data = pt[0]; in_valid = 1'b1;
      for (int cyc = 0; cyc < 100 && n_out < 3; cyc++) begin
         acc_now = in_valid && in_ready;
         out_now = out_valid && out_ready;
         if (out_now) begin
            chk($sformatf("b2b_ct_%0d", n_out), out_data, ex[n_out]);
            n_out++;
         end
         if (acc_now) begin
            acc_cyc[n_acc] = cyc;
            n_acc++;
         end
         tick();
         if (acc_now) begin
            if (n_acc < 3) in_data = pt[n_acc];
            else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      chk("b2b_out_count", 128'(n_out), 128'd3);
      chk("b2b_acc_count", 128'(n_acc), 128'd3);
      if (n_acc == 3) begin
         chk("b2b_spacing_01", 128'(acc_cyc[1] - acc_cyc[0]), 128'd12);
         chk("b2b_spacing_12", 128'(acc_cyc[2] - acc_cyc[1]), 128'd12);
      end

      // Asynchronous reset in cycle 5 of a block
      for (int k = 0; k < 5 && !in_ready; k++) tick();
      in_data = C1_PT; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      chk("mid_rk_idx_5", 128'(rk_idx), 128'd5);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_in_ready", 128'(in_ready), 128'd1);
      chk("arst_out_valid", 128'(out_valid), 128'd0);
      chk("arst_out_data", out_data, 128'd0);
      chk("arst_busy", 128'(busy), 128'd0);
      chk("arst_rk_idx", 128'(rk_idx), 128'd0);
      tick(); tick();
      rst_n = 1'b1;
      for (int k = 0; k < 14; k++) begin
         if (out_valid) chk("arst_no_valid_pulse", 128'(out_valid), 128'd0);
         tick();
      end
      send_block(C1_PT, 0, ct, seen);
      chk("arst_recover_seen", 128'(seen), 128'd1);
      chk("arst_recover_ct", ct, C1_CT);

`ifdef AES_PERF_CNT_EN
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("perf_rst_blk", 128'(blk_count), 128'd0);
      chk("perf_rst_stall", 128'(stall_count), 128'd0);
      send_block(C1_PT, 2, ct, seen);
      send_block(pt[0], 0, ct, seen);
      send_block(pt[1], 3, ct, seen);
      send_block(pt[2], 2, ct, seen);
      chk("perf_last_ct", ct, ex[2]);
      chk("perf_blk_count", 128'(blk_count), 128'd4);
      chk("perf_stall_count", 128'(stall_count), 128'd7);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
